// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle motion controller.
// Holds the default playfield geometry and the motion state encoding used by
// paddle_motion_ctrl and its velocity helper.
package paddle_pkg;

  localparam int unsigned LEFT_DEF  = 160;
  localparam int unsigned MAXX_DEF  = 320;
  localparam int unsigned TOP_DEF   = 0;
  localparam int unsigned MAXY_DEF  = 480;
  localparam int unsigned PD_SZ_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVE_L = 2'd1,
    MOVE_R = 2'd2
  } motion_state_t;

endpackage

// File: rtl/paddle_vel_sat.sv
// Combinational velocity update for one step event.
// Same direction as i_v1 (or i_v1 == 0): add/subtract i_speed, saturate to +/-VMAX.
// Opposite direction: replace velocity with +/-min(i_speed, VMAX).
// A zero speed or an unqualified step leaves the velocity unchanged.
// Ports:
//   i_v1     signed velocity before the step
//   i_valid  step qualifier
//   i_dir    step direction, 1 = right (positive)
//   i_speed  step magnitude
//   o_v      signed velocity after the step
module paddle_vel_sat #(
  parameter int unsigned VW   = 6,
  parameter int unsigned SPW  = 5,
  parameter int unsigned VMAX = 16
) (
  input  logic signed [VW-1:0]  i_v1,
  input  logic                  i_valid,
  input  logic                  i_dir,
  input  logic        [SPW-1:0] i_speed,
  output logic signed [VW-1:0]  o_v
);

  // Wide enough that v1 +/- speed can never wrap.
  localparam int unsigned SW = VW + SPW + 1;

  logic signed [SW-1:0] w_v1_ext;
  logic signed [SW-1:0] w_spd_ext;
  logic signed [SW-1:0] w_vmax;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_mag;
  logic signed [SW-1:0] w_neg_mag;
  logic                 w_same_dir;

  assign w_v1_ext  = {{(SW-VW){i_v1[VW-1]}}, i_v1};
  assign w_spd_ext = {{(SW-SPW){1'b0}}, i_speed};
  assign w_vmax    = SW'(VMAX);

  always_comb begin
    w_sum      = i_dir ? (w_v1_ext + w_spd_ext) : (w_v1_ext - w_spd_ext);
    w_mag      = (w_spd_ext > w_vmax) ? w_vmax : w_spd_ext;
    w_neg_mag  = -w_mag;
    w_same_dir = (i_v1 == '0) || (i_dir ? !i_v1[VW-1] : i_v1[VW-1]);
    o_v        = i_v1;
    if (i_valid && (i_speed != '0)) begin
      if (w_same_dir) begin
        if (w_sum > w_vmax) begin
          o_v = VW'(w_vmax);
        end else if (w_sum < -w_vmax) begin
          o_v = VW'(-w_vmax);
        end else begin
          o_v = VW'(w_sum);
        end
      end else begin
        // Instant reversal: no braking through zero.
        o_v = i_dir ? VW'(w_mag) : VW'(w_neg_mag);
      end
    end
  end

endmodule

// File: rtl/paddle_motion_ctrl.sv
// Paddle motion controller with momentum.
// Rotary steps accumulate a signed velocity; each frame tick moves the paddle by
// the pre-step velocity, applies friction decay toward zero, and clamps against
// the playfield walls (clamping zeroes the velocity and pulses wall_hit_l/_r).
// Optional build macro PADDLE_BUTTON_EN adds level buttons btn_left/btn_right
// that apply one step of magnitude speed on every tick (ignored when both held).
// Ports:
//   clock, reset_n        clock, async active-low reset
//   enable                low freezes all state, wall pulses forced low
//   tick                  frame strobe, position update point
//   rotary_event/_right   step strobe and direction (1 = right)
//   speed, length         step magnitude, paddle length in pixels
//   paddle_x, paddle_y    paddle centre
//   velocity, moving      signed velocity, velocity != 0
//   wall_hit_l/_r         one-cycle clamp pulses
module paddle_motion_ctrl
  import paddle_pkg::*;
#(
  parameter int unsigned XW       = 10,
  parameter int unsigned SPW      = 5,
  parameter int unsigned VW       = 6,
  parameter int unsigned LEFT     = LEFT_DEF,
  parameter int unsigned MAXX     = MAXX_DEF,
  parameter int unsigned TOP      = TOP_DEF,
  parameter int unsigned MAXY     = MAXY_DEF,
  parameter int unsigned PD_SZ    = PD_SZ_DEF,
  parameter int unsigned VMAX     = 16,
  parameter int unsigned FRICTION = 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           tick,
  input  logic           rotary_event,
  input  logic           rotary_right,
  input  logic [SPW-1:0] speed,
  input  logic [XW-1:0]  length,
`ifdef PADDLE_BUTTON_EN
  input  logic           btn_left,
  input  logic           btn_right,
`endif
  output logic [XW-1:0]  paddle_x,
  output logic [XW-1:0]  paddle_y,
  output logic [VW-1:0]  velocity,
  output logic           moving,
  output logic           wall_hit_l,
  output logic           wall_hit_r
);

  // Two spare bits: one for the sign, one so x + v cannot overflow.
  localparam int unsigned PW = XW + 2;

  logic          [XW-1:0] r_x;
  logic signed   [VW-1:0] r_v;
  motion_state_t          r_state;
  logic                   r_wl;
  logic                   r_wr;

  logic signed [PW-1:0] w_half;
  logic signed [PW-1:0] w_lo;
  logic signed [PW-1:0] w_hi;
  logic signed [PW-1:0] w_p;
  logic signed [VW-1:0] w_fric;
  logic signed [VW-1:0] w_v1;
  logic signed [VW-1:0] w_v_btn;
  logic signed [VW-1:0] w_v_next;
  logic        [XW-1:0] w_x_next;
  logic                 w_wl;
  logic                 w_wr;

  assign w_half = PW'(length >> 1);
  assign w_lo   = PW'(LEFT) + w_half;
  assign w_hi   = PW'(LEFT + MAXX) - w_half;
  assign w_p    = {2'b00, r_x} + {{(PW-VW){r_v[VW-1]}}, r_v};
  assign w_fric = VW'(FRICTION);

  // Tick stage: move, clamp (evaluated even at v == 0), decay.
  always_comb begin
    w_x_next = r_x;
    w_v1     = r_v;
    w_wl     = 1'b0;
    w_wr     = 1'b0;
    if (tick) begin
      if (w_p < w_lo) begin
        w_x_next = XW'(w_lo);
        w_v1     = '0;
        w_wl     = 1'b1;
      end else if (w_p > w_hi) begin
        w_x_next = XW'(w_hi);
        w_v1     = '0;
        w_wr     = 1'b1;
      end else begin
        w_x_next = XW'(w_p);
        if (r_v > w_fric) begin
          w_v1 = r_v - w_fric;
        end else if (r_v < -w_fric) begin
          w_v1 = r_v + w_fric;
        end else begin
          w_v1 = '0;
        end
      end
    end
  end

`ifdef PADDLE_BUTTON_EN
  paddle_vel_sat #(
    .VW   (VW),
    .SPW  (SPW),
    .VMAX (VMAX)
  ) u_btn_sat (
    .i_v1    (w_v1),
    .i_valid (tick & (btn_left ^ btn_right)),
    .i_dir   (btn_right),
    .i_speed (speed),
    .o_v     (w_v_btn)
  );
`else
  assign w_v_btn = w_v1;
`endif

  // Rotary step is applied last, after the tick and any button step.
  paddle_vel_sat #(
    .VW   (VW),
    .SPW  (SPW),
    .VMAX (VMAX)
  ) u_rot_sat (
    .i_v1    (w_v_btn),
    .i_valid (rotary_event),
    .i_dir   (rotary_right),
    .i_speed (speed),
    .o_v     (w_v_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_x     <= XW'(LEFT + MAXX / 2);
      r_v     <= '0;
      r_state <= IDLE;
      r_wl    <= 1'b0;
      r_wr    <= 1'b0;
    end else if (enable) begin
      r_x  <= w_x_next;
      r_v  <= w_v_next;
      r_wl <= w_wl;
      r_wr <= w_wr;
      if (w_v_next == '0) begin
        r_state <= IDLE;
      end else if (w_v_next[VW-1]) begin
        r_state <= MOVE_L;
      end else begin
        r_state <= MOVE_R;
      end
    end else begin
      r_wl <= 1'b0;
      r_wr <= 1'b0;
    end
  end

  assign paddle_x   = r_x;
  assign paddle_y   = XW'(TOP + MAXY - PD_SZ / 2);
  assign velocity   = r_v;
  assign moving     = (r_state != IDLE);
  assign wall_hit_l = r_wl;
  assign wall_hit_r = r_wr;

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
module tb_paddle_motion_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       tick;
  logic       rotary_event;
  logic       rotary_right;
  logic [4:0] speed;
  logic [9:0] length;
  logic [9:0] paddle_x;
  logic [9:0] paddle_y;
  logic [5:0] velocity;
  logic       moving;
  logic       wall_hit_l;
  logic       wall_hit_r;
`ifdef PADDLE_BUTTON_EN
  logic       btn_left  = 1'b0;
  logic       btn_right = 1'b0;
`endif

  paddle_motion_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .tick         (tick),
    .rotary_event (rotary_event),
    .rotary_right (rotary_right),
    .speed        (speed),
    .length       (length),
`ifdef PADDLE_BUTTON_EN
    .btn_left     (btn_left),
    .btn_right    (btn_right),
`endif
    .paddle_x     (paddle_x),
    .paddle_y     (paddle_y),
    .velocity     (velocity),
    .moving       (moving),
    .wall_hit_l   (wall_hit_l),
    .wall_hit_r   (wall_hit_r)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: plain integers.
  int mx = 320;
  int mv = 0;

  typedef struct {
    bit en;
    bit tk;
    bit ev;
    bit rt;
    int spd;
    int len;
    int exp_x;
    int exp_v;
  } vec_t;

  vec_t tbl[16];

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int dut_v();
    return int'($signed(velocity));
  endfunction

  // One cycle of the motion rules, written directly from the behaviour list.
  task automatic model(input bit en, input bit tk, input bit ev, input bit rt,
                       input int spd, input int len, output bit wl, output bit wr);
    int v1;
    int lo;
    int hi;
    int p;
    wl = 1'b0;
    wr = 1'b0;
    if (!en) return;
    v1 = mv;
    if (tk) begin
      lo = 160 + len / 2;
      hi = 480 - len / 2;
      p  = mx + mv;
      if (p < lo) begin
        mx = lo; v1 = 0; wl = 1'b1;
      end else if (p > hi) begin
        mx = hi; v1 = 0; wr = 1'b1;
      end else begin
        mx = p;
        if (mv > 1) v1 = mv - 1;
        else if (mv < -1) v1 = mv + 1;
        else v1 = 0;
      end
    end
    if (ev && spd != 0) begin
      if (v1 == 0 || (rt && v1 > 0) || (!rt && v1 < 0)) begin
        v1 = rt ? v1 + spd : v1 - spd;
        if (v1 > 16) v1 = 16;
        if (v1 < -16) v1 = -16;
      end else begin
        v1 = (spd > 16) ? 16 : spd;
        if (!rt) v1 = -v1;
      end
    end
    mv = v1;
  endtask

  task automatic chk_all(input string tag, input bit wl, input bit wr);
    chk({tag, ".x"}, int'(paddle_x), mx);
    chk({tag, ".y"}, int'(paddle_y), 475);
    chk({tag, ".v"}, dut_v(), mv);
    chk({tag, ".moving"}, int'(moving), int'(mv != 0));
    chk({tag, ".wall_l"}, int'(wall_hit_l), int'(wl));
    chk({tag, ".wall_r"}, int'(wall_hit_r), int'(wr));
  endtask

  // Drive one cycle, advance the model, compare just after the edge.
  task automatic step(input bit en, input bit tk, input bit ev, input bit rt,
                      input int spd, input int len, input string tag);
    bit wl;
    bit wr;
    enable       = en;
    tick         = tk;
    rotary_event = ev;
    rotary_right = rt;
    speed        = spd[4:0];
    length       = len[9:0];
    model(en, tk, ev, rt, spd, len, wl, wr);
    @(posedge clock);
    #1;
    chk_all(tag, wl, wr);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1,  4, 40, 320,   4};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1,  4, 40, 320,   8};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1,  4, 40, 320,  12};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  4, 40, 332,  11};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1,  4, 40, 332,  15};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1,  4, 40, 332,  16};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0,  4, 40, 332,  -4};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1,  4, 40, 328,   4};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0,  4, 40, 328,   4};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1,  0, 40, 332,   3};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1,  2, 40, 332,   5};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1,  4, 40, 337,   8};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 31, 40, 337, -16};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 40, 321, -15};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0,  0, 40, 306, -14};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0,  0, 40, 292, -13};

    reset_n      = 1'b0;
    enable       = 1'b0;
    tick         = 1'b0;
    rotary_event = 1'b0;
    rotary_right = 1'b0;
    speed        = '0;
    length       = 10'd40;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 1'b0, 1'b0);
    reset_n = 1'b1;

    // Directed table: accumulate, saturate, reverse, freeze, same-cycle tick+step.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].en, tbl[i].tk, tbl[i].ev, tbl[i].rt, tbl[i].spd, tbl[i].len,
           $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.x_const", i), int'(paddle_x), tbl[i].exp_x);
      chk($sformatf("tbl%0d.v_const", i), dut_v(), tbl[i].exp_v);
    end

    // Right wall: reverse to +16, push at full speed to 452, then clamp at 460.
    step(1'b1, 1'b0, 1'b1, 1'b1, 31, 40, "rev");
    chk("rev.v_const", dut_v(), 16);
    repeat (10) step(1'b1, 1'b1, 1'b1, 1'b1, 31, 40, "push");
    chk("push.x_const", int'(paddle_x), 452);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 40, "clamp_r");
    chk("clamp_r.x_const", int'(paddle_x), 460);
    chk("clamp_r.v_const", dut_v(), 0);
    chk("clamp_r.pulse", int'(wall_hit_r), 1);
    chk("clamp_r.moving", int'(moving), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 40, "after_r");
    chk("after_r.pulse_gone", int'(wall_hit_r), 0);

    // Freeze, then a longer paddle re-clamps on the next tick with v == 0.
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, 4, 100, "freeze");
    chk("freeze.x_const", int'(paddle_x), 460);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 100, "len");
    chk("len.x_const", int'(paddle_x), 430);
    chk("len.pulse", int'(wall_hit_r), 1);

    // Left wall at lo = 210.
    step(1'b1, 1'b0, 1'b1, 1'b0, 31, 100, "go_l");
    repeat (13) step(1'b1, 1'b1, 1'b1, 1'b0, 31, 100, "push_l");
    chk("push_l.x_const", int'(paddle_x), 222);
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 100, "clamp_l");
    chk("clamp_l.x_const", int'(paddle_x), 210);
    chk("clamp_l.pulse", int'(wall_hit_l), 1);

    // Asynchronous reset between clock edges.
    #2;
    reset_n = 1'b0;
    #1;
    mx = 320;
    mv = 0;
    chk_all("async_rst", 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;

    // Randomised run against the reference model.
    for (int i = 0; i < 400; i++) begin
      int len;
      len = (i % 50 < 25) ? 40 : int'($urandom_range(0, 200));
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 31)), len,
           $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
